pll_reconfig_master: RTL and testbench

- Avalon-MM master that reprograms the pixel/memory PLL at run time through the PLL reconfiguration controller. The controller's reconfig_to_pll / reconfig_from_pll buses connect to the reconfigurable PLL.
- On a request, it writes mode, N, M and every C counter, then triggers the reconfiguration, waits for relock and reports done or error.
- Sits in the clock domain of the PLL reference clock (50 MHz), between the video mode-select logic and the reconfig IP.

---
 rtl/pll_reconfig_master.sv | 182 ++++++++++++++++++
 tb/tb_pll_reconfig_master.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reconfig_master.sv
// pll_reconfig_master: Avalon-MM master that programs a reconfigurable PLL
// through its reconfiguration controller. The sequence is: mode, N, M, every
// C counter, then start. After the start write it waits for the PLL to relock
// and reports done, or reports error on a lock timeout.
module pll_reconfig_master #(
    parameter int NUM_C         = 3,
    parameter int SETTLE_CYCLES = 16,
    parameter int LOCK_TIMEOUT  = 500000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_req,
    input  logic [17:0]           n_cfg,
    input  logic [17:0]           m_cfg,
    input  logic [18*NUM_C-1:0]   c_cfg,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [5:0]            mgmt_address,
    output logic                  mgmt_write,
    output logic [31:0]           mgmt_writedata,
    output logic                  mgmt_read,
    input  logic                  mgmt_waitrequest,
    input  logic                  pll_locked
);

    // One counter serves both the settle delay and the lock timeout, so it is
    // sized for the larger of the two terminal counts.
    localparam int CNT_MAX = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    // Five index bits cover up to 32 C counters, enough for the 18 a PLL has.
    localparam logic [4:0]       IDX_LAST    = 5'(NUM_C - 1);

    localparam logic [5:0] ADDR_MODE  = 6'h00;
    localparam logic [5:0] ADDR_START = 6'h02;
    localparam logic [5:0] ADDR_N     = 6'h03;
    localparam logic [5:0] ADDR_M     = 6'h04;
    localparam logic [5:0] ADDR_C     = 6'h05;

    typedef enum logic [2:0] {
        IDLE, WR_MODE, WR_N, WR_M, WR_C, WR_START, SETTLE, WAIT_LOCK
    } state_t;

    state_t              state;
    logic [17:0]         n_sh;
    logic [17:0]         m_sh;
    logic [18*NUM_C-1:0] c_sh;
    logic [4:0]          idx;
    logic [CNT_W-1:0]    cnt;
    logic [1:0]          lock_sync;
    logic                accept;

    // This master only writes.
    assign mgmt_read = 1'b0;
    assign accept    = mgmt_write & ~mgmt_waitrequest;

    // N/M register word: the 18-bit counter setting in the low bits.
    function automatic logic [31:0] nm_word(input logic [17:0] v);
        return {14'b0, v};
    endfunction

    // C register word: the counter index sits above the 18-bit setting.
    function automatic logic [31:0] c_word(input logic [4:0] i, input logic [18*NUM_C-1:0] cv);
        return {9'b0, i, cv[18*int'(i) +: 18]};
    endfunction

    // Bring the asynchronous lock indication into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_sync <= 2'b00;
        end else begin
            lock_sync <= {lock_sync[0], pll_locked};
        end
    end

    // Sequencer. Each write state advances on acceptance and presents the
    // next write in the same cycle, so writes run back to back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            n_sh           <= '0;
            m_sh           <= '0;
            c_sh           <= '0;
            idx            <= '0;
            cnt            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            mgmt_address   <= '0;
            mgmt_write     <= 1'b0;
            mgmt_writedata <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_req) begin
                        n_sh           <= n_cfg;
                        m_sh           <= m_cfg;
                        c_sh           <= c_cfg;
                        busy           <= 1'b1;
                        mgmt_write     <= 1'b1;
                        mgmt_address   <= ADDR_MODE;
                        mgmt_writedata <= 32'd0;
                        state          <= WR_MODE;
                    end
                end
                WR_MODE: begin
                    if (accept) begin
                        mgmt_address   <= ADDR_N;
                        mgmt_writedata <= nm_word(n_sh);
                        state          <= WR_N;
                    end
                end
                WR_N: begin
                    if (accept) begin
                        mgmt_address   <= ADDR_M;
                        mgmt_writedata <= nm_word(m_sh);
                        state          <= WR_M;
                    end
                end
                WR_M: begin
                    if (accept) begin
                        idx            <= 5'd0;
                        mgmt_address   <= ADDR_C;
                        mgmt_writedata <= c_word(5'd0, c_sh);
                        state          <= WR_C;
                    end
                end
                WR_C: begin
                    if (accept) begin
                        if (idx == IDX_LAST) begin
                            mgmt_address   <= ADDR_START;
                            mgmt_writedata <= 32'd1;
                            state          <= WR_START;
                        end else begin
                            idx            <= idx + 5'd1;
                            mgmt_writedata <= c_word(idx + 5'd1, c_sh);
                        end
                    end
                end
                WR_START: begin
                    // The controller holds waitrequest for the whole
                    // reconfiguration, so acceptance means it has finished.
                    if (accept) begin
                        mgmt_write     <= 1'b0;
                        mgmt_address   <= '0;
                        mgmt_writedata <= '0;
                        cnt            <= '0;
                        state          <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        state <= WAIT_LOCK;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    // Lock is tested first so it wins over a same-cycle timeout.
                    if (lock_sync[1]) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == LOCK_LAST) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reconfig_master.sv
// Testbench for pll_reconfig_master. An Avalon slave responder applies
// waitrequest stalls and records the accepted writes. A lock responder raises
// pll_locked a chosen number of cycles after the start write is accepted.
// Each operation is compared against a write list and a done/error timing
// derived directly from the register map and the lock rules.
module tb_pll_reconfig_master;

    localparam int NC  = 3;
    localparam int SET = 16;
    localparam int TO  = 1000;

    logic               clk;
    logic               rst;
    logic               cfg_req;
    logic [17:0]        n_cfg;
    logic [17:0]        m_cfg;
    logic [18*NC-1:0]   c_cfg;
    logic               busy;
    logic               done;
    logic               error;
    logic [5:0]         mgmt_address;
    logic               mgmt_write;
    logic [31:0]        mgmt_writedata;
    logic               mgmt_read;
    logic               mgmt_waitrequest;
    logic               pll_locked;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc  = -1;
    int lock_delay = -1;
    int stall_mode = 0;
    logic [37:0] got[$];

    pll_reconfig_master #(
        .NUM_C(NC), .SETTLE_CYCLES(SET), .LOCK_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .cfg_req(cfg_req),
        .n_cfg(n_cfg), .m_cfg(m_cfg), .c_cfg(c_cfg),
        .busy(busy), .done(done), .error(error),
        .mgmt_address(mgmt_address), .mgmt_write(mgmt_write),
        .mgmt_writedata(mgmt_writedata), .mgmt_read(mgmt_read),
        .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        n_checks++;
        if (obs !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, req, cyc);
        end
    endtask

    function automatic int stall_for(input logic [5:0] a);
        if (stall_mode == 1) return (a == 6'h04) ? 5 : (a == 6'h02) ? 100 : 0;
        if (stall_mode == 2) return (a == 6'h02) ? int'($urandom_range(0, 30)) : int'($urandom_range(0, 3));
        return 0;
    endfunction

    function automatic logic [18*NC-1:0] rand_c();
        logic [18*NC-1:0] v;
        for (int i = 0; i < NC; i++) v[18*i +: 18] = 18'($urandom);
        return v;
    endfunction

    // Avalon slave responder and lock generator.
    initial begin
        logic [37:0] held;
        int stall_left;
        bit in_wr;
        in_wr = 0;
        stall_left = 0;
        held = '0;
        mgmt_waitrequest = 1'b0;
        forever begin
            @(negedge clk);
            if (lock_delay >= 0 && start_cyc >= 0 && cyc == start_cyc + lock_delay - 1)
                pll_locked = 1'b1;
            if (mgmt_write) begin
                if (!in_wr) begin
                    in_wr = 1;
                    held = {mgmt_address, mgmt_writedata};
                    stall_left = stall_for(mgmt_address);
                end else begin
                    chk("stable", {mgmt_address, mgmt_writedata}, held);
                end
                if (stall_left > 0) begin
                    mgmt_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    mgmt_waitrequest = 1'b0;
                    in_wr = 0;
                    got.push_back(held);
                    if (held[37:32] == 6'h02) start_cyc = cyc + 1;
                end
            end else begin
                mgmt_waitrequest = 1'b0;
                in_wr = 0;
            end
        end
    end

    // One reconfiguration: request, watch for the end, compare with the model.
    task automatic run_op(input logic [17:0] n, input logic [17:0] m, input logic [18*NC-1:0] c,
                          input int smode, input int ld, input bit exp_done,
                          input bit inj_busy, input bit inj_rst);
        logic [37:0] exp_q[$];
        int ndone, nerr, t_end, gaps, exp_t;
        bit fired, clr_req, finished;
        exp_q.push_back({6'h00, 32'h0});
        exp_q.push_back({6'h03, 14'b0, n});
        exp_q.push_back({6'h04, 14'b0, m});
        for (int i = 0; i < NC; i++) exp_q.push_back({6'h05, 9'b0, 5'(i), c[18*i +: 18]});
        exp_q.push_back({6'h02, 32'h1});
        stall_mode = smode;
        lock_delay = ld;
        start_cyc  = -1;
        pll_locked = 1'b0;
        ndone = 0; nerr = 0; t_end = -1; gaps = 0;
        fired = 0; clr_req = 0; finished = 0;
        @(negedge clk);
        got.delete();
        n_cfg = n; m_cfg = m; c_cfg = c; cfg_req = 1'b1;
        @(negedge clk);
        cfg_req = 1'b0;
        n_cfg = 18'($urandom); m_cfg = 18'($urandom); c_cfg = rand_c();
        for (int steps = 0; steps < 5000 && !finished; steps++) begin
            if (clr_req) begin
                cfg_req = 1'b0;
                clr_req = 0;
            end
            if (done || error) begin
                ndone += int'(done);
                nerr  += int'(error);
                t_end = cyc;
                chk("busy_at_end", busy, 0);
                finished = 1;
            end else begin
                if (!busy) gaps++;
                if (inj_busy && !fired && mgmt_write && mgmt_address == 6'h05) begin
                    fired = 1;
                    m_cfg = m ^ 18'h3FFFF;
                    n_cfg = ~n;
                    cfg_req = 1'b1;
                    clr_req = 1;
                end
                if (inj_rst && mgmt_write && mgmt_address == 6'h05 && mgmt_writedata[22:18] == 5'd1) begin
                    rst = 1'b1;
                    #1;
                    chk("rst_write", mgmt_write, 0);
                    chk("rst_busy", busy, 0);
                    @(negedge clk);
                    rst = 1'b0;
                    return;
                end
                @(negedge clk);
            end
        end
        cfg_req = 1'b0;
        if (!finished) chk("op_budget", 0, 1);
        repeat (3) begin
            @(negedge clk);
            ndone += int'(done);
            nerr  += int'(error);
        end
        chk("busy_idle", busy, 0);
        chk("done_cnt", ndone, exp_done ? 1 : 0);
        chk("err_cnt", nerr, exp_done ? 0 : 1);
        // Lock needs two clk edges through the synchronizer; the earliest
        // decision is one cycle after WAIT_LOCK is entered at start+SET.
        exp_t = exp_done ? ((SET + 1 > ld + 2) ? SET + 1 : ld + 2) : SET + TO;
        chk("end_time", t_end - start_cyc, exp_t);
        chk("busy_hold", gaps, 0);
        chk("nwrites", got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk("write", got[i], exp_q[i]);
    endtask

    initial begin
        logic [18*NC-1:0] c143;
        rst = 1'b1; cfg_req = 1'b0; n_cfg = '0; m_cfg = '0; c_cfg = '0; pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy0", busy, 0);
        chk("rst_done0", done, 0);
        chk("rst_error0", error, 0);
        chk("rst_write0", mgmt_write, 0);
        chk("rst_addr0", mgmt_address, 0);
        chk("rst_data0", mgmt_writedata, 0);
        chk("rst_read0", mgmt_read, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);

        c143 = {3{18'h20302}};
        run_op(18'h00505, 18'h24847, c143, 0, 20, 1, 0, 0);
        run_op(18'h00505, 18'h24847, c143, 1, 20, 1, 0, 0);
        run_op(18'($urandom), 18'($urandom), rand_c(), 0, -1, 0, 0, 0);
        run_op(18'($urandom), 18'($urandom), rand_c(), 2, 30, 1, 1, 0);
        run_op(18'($urandom), 18'($urandom), rand_c(), 0, 20, 1, 0, 1);
        run_op(18'($urandom), 18'($urandom), rand_c(), 0, 25, 1, 0, 0);
        run_op(18'($urandom), 18'($urandom), rand_c(), 0, SET + TO - 2, 1, 0, 0);
        run_op(18'($urandom), 18'($urandom), rand_c(), 0, SET + TO - 1, 0, 0, 0);
        for (int k = 0; k < 6; k++)
            run_op(18'($urandom), 18'($urandom), rand_c(), 2, int'($urandom_range(5, 60)), 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
